// File: rtl/maze_pkg.sv
// Shared types and widths for the maze map-ROM arbiter slice.
package maze_pkg;
  localparam int ROW_W    = 3;
  localparam int COL_W    = 3;
  localparam int ROW_BITS = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_LATCH = 2'd2
  } state_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: req[0]=A, req[1]=B; last=1 means B was served last.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] win
);
  always_comb begin
    win = 2'b00;
    case (req)
      2'b01:   win = 2'b01;
      2'b10:   win = 2'b10;
      2'b11:   win = last ? 2'b01 : 2'b10;
      default: win = 2'b00;
    endcase
  end
endmodule

// File: rtl/maprom_arbiter.sv
// Shares one registered map ROM between the display scanner (A, whole rows)
// and the move checker (B, single cells). One access per three cycles.
//
// state    | meaning
// ST_IDLE  | pick a winner from pending requests; valid pulses land here
// ST_READ  | rom_en high, winner's gnt pulses
// ST_LATCH | ROM data available, captured at the closing edge
module maprom_arbiter
  import maze_pkg::*;
#(
  parameter bit FAIR = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                a_req,
  input  logic [ROW_W-1:0]    a_row,
  output logic                a_gnt,
  output logic                a_valid,
  output logic [ROW_BITS-1:0] a_rowdata,
  input  logic                b_req,
  input  logic [ROW_W-1:0]    b_row,
  input  logic [COL_W-1:0]    b_col,
  output logic                b_gnt,
  output logic                b_valid,
  output logic                b_open,
  output logic                rom_en,
  output logic [ROW_W-1:0]    rom_addr,
  input  logic [ROW_BITS:0]   rom_data
);
  state_t           state, state_nxt;
  logic             serve_b;
  logic             last_b;
  logic [COL_W-1:0] col_q;
  logic [1:0]       rr_win, fixed_win, win;
  logic             take;

  rr_arb2 u_rr_arb2 (
    .req  ({b_req, a_req}),
    .last (last_b),
    .win  (rr_win)
  );

  assign fixed_win = b_req ? 2'b10 : {1'b0, a_req};
  assign win       = FAIR ? rr_win : fixed_win;
  assign take      = (state == ST_IDLE) && (win != 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rom_en    = 1'b0;
    a_gnt     = 1'b0;
    b_gnt     = 1'b0;
    case (state)
      ST_IDLE:  if (take) state_nxt = ST_READ;
      ST_READ: begin
        rom_en    = 1'b1;
        a_gnt     = !serve_b;
        b_gnt     = serve_b;
        state_nxt = ST_LATCH;
      end
      ST_LATCH: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Column 0 is the MSB, so bit index 7-col is simply the inverted column.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      serve_b   <= 1'b0;
      last_b    <= 1'b1;
      col_q     <= '0;
      rom_addr  <= '0;
      a_rowdata <= '0;
      b_open    <= 1'b0;
      a_valid   <= 1'b0;
      b_valid   <= 1'b0;
    end else begin
      a_valid <= 1'b0;
      b_valid <= 1'b0;
      if (take) begin
        serve_b  <= win[1];
        last_b   <= win[1];
        rom_addr <= win[1] ? b_row : a_row;
        if (win[1]) col_q <= b_col;
      end
      if (state == ST_LATCH) begin
        if (serve_b) begin
          b_open  <= rom_data[{1'b0, ~col_q}];
          b_valid <= 1'b1;
        end else begin
          a_rowdata <= rom_data[ROW_BITS-1:0];
          a_valid   <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_maprom_arbiter.sv
// Directed bench: one fair and one fixed-priority arbiter, each on its own ROM model.
module tb_maprom_arbiter;
  logic       clk = 1'b0;
  logic       rst_n;
  int         n_tests = 0;
  int         n_fail  = 0;

  logic       a_req, a_gnt, a_valid, b_req, b_gnt, b_valid, b_open, rom_en;
  logic [2:0] a_row, b_row, b_col, rom_addr;
  logic [7:0] a_rowdata;
  logic [8:0] rom_data;

  logic       a_req0, a_gnt0, a_valid0, b_req0, b_gnt0, b_valid0, b_open0, rom_en0;
  logic [2:0] a_row0, b_row0, b_col0, rom_addr0;
  logic [7:0] a_rowdata0;
  logic [8:0] rom_data0;

  always #5 clk = ~clk;

  maprom_arbiter #(.FAIR(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_row(a_row), .a_gnt(a_gnt), .a_valid(a_valid), .a_rowdata(a_rowdata),
    .b_req(b_req), .b_row(b_row), .b_col(b_col), .b_gnt(b_gnt), .b_valid(b_valid), .b_open(b_open),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data)
  );

  maprom_arbiter #(.FAIR(1'b0)) dut_fix (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req0), .a_row(a_row0), .a_gnt(a_gnt0), .a_valid(a_valid0), .a_rowdata(a_rowdata0),
    .b_req(b_req0), .b_row(b_row0), .b_col(b_col0), .b_gnt(b_gnt0), .b_valid(b_valid0), .b_open(b_open0),
    .rom_en(rom_en0), .rom_addr(rom_addr0), .rom_data(rom_data0)
  );

  function automatic logic [7:0] rom_row(input logic [2:0] r);
    case (r)
      3'd0: rom_row = 8'h81;
      3'd1: rom_row = 8'b11111100;
      3'd2: rom_row = 8'h3C;
      3'd3: rom_row = 8'b11101010;
      3'd4: rom_row = 8'h55;
      3'd5: rom_row = 8'hAA;
      3'd6: rom_row = 8'h0F;
      default: rom_row = 8'hF0;
    endcase
  endfunction

  // Bit 8 forced high so any use of it shows up.
  always @(posedge clk) begin
    if (rom_en)  rom_data  <= {1'b1, rom_row(rom_addr)};
    if (rom_en0) rom_data0 <= {1'b1, rom_row(rom_addr0)};
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; rom_data = '0; rom_data0 = '0;
    a_req = 0; a_row = 0; b_req = 0; b_row = 0; b_col = 0;
    a_req0 = 0; a_row0 = 0; b_req0 = 0; b_row0 = 0; b_col0 = 0;
    repeat (2) @(negedge clk);
    chk("rst gnt/valid", {a_gnt, b_gnt, a_valid, b_valid}, 4'b0000);
    chk("rst rom_en", rom_en, 1'b0);
    chk("rst rom_addr", rom_addr, 3'd0);
    chk("rst a_rowdata", a_rowdata, 8'h00);
    chk("rst b_open", b_open, 1'b0);
    rst_n = 1'b1;

    // Single A read of row 1
    a_req = 1; a_row = 3'd1;
    tick();
    chk("a gnt c1", {a_gnt, b_gnt}, 2'b10);
    chk("a rom_en c1", rom_en, 1'b1);
    chk("a rom_addr c1", rom_addr, 3'd1);
    a_req = 0;
    tick();
    chk("a latch c2", {rom_en, a_gnt, a_valid}, 3'b000);
    tick();
    chk("a valid c3", a_valid, 1'b1);
    chk("a rowdata c3", a_rowdata, 8'hFC);
    tick();
    chk("a valid c4", a_valid, 1'b0);
    chk("a rowdata hold", a_rowdata, 8'hFC);

    // B cell queries on row 3
    for (int k = 0; k < 2; k++) begin
      b_req = 1; b_row = 3'd3; b_col = (k == 0) ? 3'd3 : 3'd2;
      tick();
      chk($sformatf("b%0d gnt", k), {a_gnt, b_gnt, rom_en}, 3'b011);
      chk($sformatf("b%0d addr", k), rom_addr, 3'd3);
      b_req = 0;
      tick();
      chk($sformatf("b%0d c2 valid", k), b_valid, 1'b0);
      tick();
      chk($sformatf("b%0d valid", k), b_valid, 1'b1);
      chk($sformatf("b%0d open", k), b_open, (k == 0) ? 1'b0 : 1'b1);
    end

    // Both held: A,B,A,B every 3 cycles (last served was B)
    a_req = 1; a_row = 3'd2; b_req = 1; b_row = 3'd3; b_col = 3'd2;
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk($sformatf("rr c%0d", i), {a_gnt, b_gnt, a_valid, b_valid},
          {(i % 6) == 1, (i % 6) == 4, (i % 6) == 3, (i % 6) == 0});
    end
    a_req = 0; b_req = 0;
    chk("rr a_rowdata", a_rowdata, 8'h3C);
    chk("rr b_open", b_open, 1'b1);

    // Idle: nothing moves
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("idle c%0d", i), {rom_en, rom_addr}, {1'b0, 3'd3});
    end

    // Fixed priority: B wins while held, A only after B drops
    a_req0 = 1; a_row0 = 3'd1; b_req0 = 1; b_row0 = 3'd3; b_col0 = 3'd3;
    for (int i = 1; i <= 7; i++) begin
      tick();
      chk($sformatf("fix c%0d", i), {a_gnt0, b_gnt0},
          (i == 1 || i == 4) ? 2'b01 : (i == 7) ? 2'b10 : 2'b00);
      if (i == 4) b_req0 = 0;
      if (i == 7) a_req0 = 0;
    end
    tick(); tick();
    chk("fix a valid", a_valid0, 1'b1);
    chk("fix a rowdata", a_rowdata0, 8'hFC);

    // Reset during LATCH: abandon, no valid, re-grant after release
    a_req = 1; a_row = 3'd1;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("mid rst outs", {a_gnt, b_gnt, rom_en, a_valid, b_valid}, 5'b0);
    chk("mid rst addr", rom_addr, 3'd0);
    chk("mid rst rowdata", a_rowdata, 8'h00);
    chk("mid rst b_open", b_open, 1'b0);
    @(posedge clk); @(negedge clk);
    chk("mid rst no valid", a_valid, 1'b0);
    rst_n = 1'b1;
    tick();
    chk("post rst regrant", {a_gnt, a_valid}, 2'b10);
    a_req = 0;
    tick(); tick();
    chk("post rst valid", a_valid, 1'b1);
    chk("post rst rowdata", a_rowdata, 8'hFC);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/maprom_arbiter.md
MAPROM_ARBITER -- requirements
Module: maprom_arbiter

Interface
REQ-001 SHALL have parameter FAIR, default 1: 1 = round-robin between A and B; 0 = B has fixed priority over A.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port a_req, input, 1: display-scanner request, held high until a_gnt.
REQ-005 SHALL have port a_row, input, 3: row requested by A, held stable while a_req is high.
REQ-006 SHALL have port a_gnt, output, 1: one-cycle pulse, A's request is issued to the ROM.
REQ-007 SHALL have port a_valid, output, 1: one-cycle pulse, a_rowdata holds A's result.
REQ-008 SHALL have port a_rowdata, output, 8: row bits, 1 = open cell.
REQ-009 SHALL have port b_req, input, 1: move-checker request, held high until b_gnt.
REQ-010 SHALL have ports b_row and b_col, input, 3 each: cell queried by B, held stable while b_req is high.
REQ-011 SHALL have port b_gnt, output, 1: one-cycle pulse, B's request is issued.
REQ-012 SHALL have port b_valid, output, 1: one-cycle pulse, b_open holds B's result.
REQ-013 SHALL have port b_open, output, 1: 1 = queried cell is open.
REQ-014 SHALL have port rom_en, output, 1: ROM read enable.
REQ-015 SHALL have port rom_addr, output, 3: ROM row address.
REQ-016 SHALL have port rom_data, input, 9: registered ROM output, one-cycle read latency; bit 8 is ignored.

Function
REQ-017 SHALL implement FSM IDLE -> READ -> LATCH -> IDLE; one ROM access per 3 cycles maximum.
REQ-018 In IDLE with any req high, the SHALL select a winner at the clock edge, register its row into rom_addr (and b_col if B wins), and enter READ; with no req, SHALL stay in IDLE.
REQ-019 In READ, SHALL drive rom_en=1 and assert the winner's gnt for exactly that cycle; in every other state, rom_en=0 and both gnts are 0.
REQ-020 In LATCH, SHALL capture the result at the clock edge: A wins -> a_rowdata=rom_data[7:0]; B wins -> b_open=rom_data[7-b_col]; column 0 is the MSB.
REQ-021 SHALL pulse the winner's valid in the IDLE cycle following LATCH; latency from the req-sampling edge to the valid cycle SHALL be 3 cycles.
REQ-022 A req still high in a valid cycle SHALL be treated as a new request, which may win at that edge.
REQ-023 a_rowdata and b_open SHALL hold their values until the next capture for the same requester.
REQ-024 With FAIR=1 and both reqs high, the SHALL grant the requester not served last; the first tie after reset goes to A.
REQ-025 With FAIR=0 and both reqs high, SHALL always grant B.
REQ-026 The losing req SHALL stay pending with no gnt; it SHALL be served at the next IDLE decision.
REQ-027 rom_addr SHALL hold its last value outside READ.
REQ-028 Requests arriving during READ or LATCH SHALL be ignored until IDLE.

Reset
REQ-029 rst_n low SHALL immediately force: state=IDLE, all gnt/valid=0, rom_en=0, rom_addr=0, a_rowdata=0, b_open=0, last-served=B.
REQ-030 Reset mid-transaction SHALL abandon the access; no valid pulse SHALL follow it.

Structure
REQ-031 Package maze_pkg SHALL hold: the FSM state enum, ROW_W=3, COL_W=3, ROW_BITS=8.
REQ-032 The 2-way round-robin decision SHALL be a sub-module rr_arb2 (inputs req[1:0] and last; output one-hot win).

Verification
REQ-033 With a ROM model row1=8'b11111100, a_req with a_row=1 at edge 0 -> a_gnt in cycle 1, rom_en=1 and rom_addr=1 in cycle 1, a_valid in cycle 3, a_rowdata=8'hFC.
REQ-034 With row3=8'b11101010, b_req with row 3 and col 3 -> b_open=0; col 2 -> b_open=1; b_valid 3 cycles after request.
REQ-035 With FAIR=1, both reqs held continuously -> gnt order A, B, A, B, spaced 3 cycles apart; neither requester starves.
REQ-036 With FAIR=0, both reqs high -> B is granted first; A is granted only after B drops its req.
REQ-037 rst_n asserted in the LATCH cycle -> outputs zero at once; no valid pulse afterward; a held req is re-granted 1 cycle after rst_n releases.
REQ-038 Requests idle -> rom_en stays 0 and rom_addr is unchanged for 10 cycles.
